// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I opcodes, decode-to-execute entry layout and writeback snoop helper.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;
  typedef struct packed {
    logic [4:0]      opcode;
    logic [2:0]      func3;
    logic            func7;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] store;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_rs1;
    logic            use_rs2_op2;
    logic            use_rs2_store;
  } entry_t;
  // Replace any operand field sourced from the written register; x0 never matches.
  function automatic entry_t wb_snoop(entry_t e, logic en, logic [4:0] rd, logic [XLEN-1:0] data);
    entry_t r;
    logic hit1, hit2;
    r    = e;
    hit1 = en && rd != 5'd0 && rd == e.rs1;
    hit2 = en && rd != 5'd0 && rd == e.rs2;
    r.op1   = hit1 && e.use_rs1 ? data : e.op1;
    r.op2   = hit2 && e.use_rs2_op2 ? data : e.op2;
    r.store = hit2 && e.use_rs2_store ? data : e.store;
    return r;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side offer, writeback snoop and execute-side handshake of the ID/EX stage.
interface id_ex_stage_if;
  import rv32_pkg::*;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_opcode;
  logic [2:0]      ex_func3;
  logic            ex_func7;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_store;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_pc;
  modport master (
    output flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, wb_en, wb_rd, wb_data, ex_ready,
    input  in_ready, ex_valid, ex_opcode, ex_func3, ex_func7, ex_op1, ex_op2, ex_store, ex_rd, ex_pc
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, wb_en, wb_rd, wb_data, ex_ready,
    output in_ready, ex_valid, ex_opcode, ex_func3, ex_func7, ex_op1, ex_op2, ex_store, ex_rd, ex_pc
  );
endinterface

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate of the instruction's format, zero for formats without one.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:7]     instr_i,
  input  logic [4:0]      opc_i,
  output logic [XLEN-1:0] imm_o
);
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_o = opc_i inside {OP_LUI, OP_AUIPC}          ? imm_u :
                 opc_i == OP_JAL                          ? imm_j :
                 opc_i inside {OP_JALR, OP_LOAD, OP_IMM}  ? imm_i :
                 opc_i == OP_STORE                        ? imm_s :
                 opc_i == OP_BRANCH                       ? imm_b : '0;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode-to-execute register with operand select, 2-entry skid buffer
// and writeback snooping of captured and held operands.
module id_ex_stage
  import rv32_pkg::*;
(
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  logic [4:0]      opc;
  logic [XLEN-1:0] imm;
  logic            use1, use2o, use2s, pc_rel, acc, in_ready_q, ex_valid_q;
  entry_t          raw_e, new_e, main_q, main_d, main_s, skid_q, skid_d, skid_s;
  state_e          state_q, state_d;
  assign opc = bus.in_instr[6:2];
  imm_gen u_imm (.instr_i(bus.in_instr[31:7]), .opc_i(opc), .imm_o(imm));
  assign use1   = opc inside {OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
  assign use2o  = opc inside {OP_BRANCH, OP_REG};
  assign use2s  = opc inside {OP_BRANCH, OP_STORE, OP_REG};
  assign pc_rel = opc inside {OP_AUIPC, OP_JAL, OP_JALR};
  assign raw_e = '{
    opcode:        opc,
    func3:         bus.in_instr[14:12],
    func7:         bus.in_instr[30],
    op1:           use1 ? bus.in_rs1_data : pc_rel ? bus.in_pc : '0,
    op2:           use2o ? bus.in_rs2_data : imm,
    store:         bus.in_rs2_data,
    pc:            bus.in_pc,
    rd:            bus.in_instr[11:7],
    rs1:           bus.in_instr[19:15],
    rs2:           bus.in_instr[24:20],
    use_rs1:       use1,
    use_rs2_op2:   use2o,
    use_rs2_store: use2s
  };
  // Capture bypass and hold snoop share one rule so every entry sees the same writeback.
  assign new_e  = wb_snoop(raw_e, bus.wb_en, bus.wb_rd, bus.wb_data);
  assign main_s = wb_snoop(main_q, bus.wb_en, bus.wb_rd, bus.wb_data);
  assign skid_s = wb_snoop(skid_q, bus.wb_en, bus.wb_rd, bus.wb_data);
  assign acc = bus.in_valid & in_ready_q & ~bus.flush;
  always_comb begin
    state_d = bus.flush           ? ST_EMPTY :
              state_q == ST_EMPTY ? (acc ? ST_ONE : ST_EMPTY) :
              state_q == ST_ONE   ? (acc ? (bus.ex_ready ? ST_ONE : ST_TWO) : (bus.ex_ready ? ST_EMPTY : ST_ONE)) :
                                    (bus.ex_ready ? ST_ONE : ST_TWO);
    main_d  = acc && (state_q == ST_EMPTY || bus.ex_ready) ? new_e :
              state_q == ST_TWO && bus.ex_ready            ? skid_s : main_s;
    skid_d  = acc && state_q == ST_ONE && !bus.ex_ready ? new_e : skid_s;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= state_d != ST_TWO;
      ex_valid_q <= state_d != ST_EMPTY;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_opcode = main_q.opcode;
  assign bus.ex_func3  = main_q.func3;
  assign bus.ex_func7  = main_q.func7;
  assign bus.ex_op1    = main_q.op1;
  assign bus.ex_op2    = main_q.op2;
  assign bus.ex_store  = main_q.store;
  assign bus.ex_rd     = main_q.rd;
  assign bus.ex_pc     = main_q.pc;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage with directed cases and a random traffic phase.
module tb_id_ex_stage;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  item_t q[$];
  id_ex_stage_if bus();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic reads_rs1(logic [4:0] o);
    case (o)
      5'b11000, 5'b00000, 5'b01000, 5'b00100, 5'b01100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic reads_rs2(logic [4:0] o);
    case (o)
      5'b11000, 5'b01000, 5'b01100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic item_t apply_wb(item_t it, logic en, logic [4:0] rd, logic [31:0] d);
    item_t r = it;
    if (en && rd != 0) begin
      if (reads_rs1(it.instr[6:2]) && rd == it.instr[19:15]) r.r1 = d;
      if (reads_rs2(it.instr[6:2]) && rd == it.instr[24:20]) r.r2 = d;
    end
    return r;
  endfunction
  function automatic void model(input item_t it, output logic [31:0] op1, output logic [31:0] op2);
    logic [31:0] in, ii, is, iu, ij;
    in = it.instr;
    ii = {{20{in[31]}}, in[31:20]};
    is = {{20{in[31]}}, in[31:25], in[11:7]};
    iu = {in[31:12], 12'd0};
    ij = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
    case (in[6:2])
      5'b01101: begin op1 = 0;     op2 = iu;    end
      5'b00101: begin op1 = it.pc; op2 = iu;    end
      5'b11011: begin op1 = it.pc; op2 = ij;    end
      5'b11001: begin op1 = it.pc; op2 = ii;    end
      5'b11000: begin op1 = it.r1; op2 = it.r2; end
      5'b00000: begin op1 = it.r1; op2 = ii;    end
      5'b01000: begin op1 = it.r1; op2 = is;    end
      5'b00100: begin op1 = it.r1; op2 = ii;    end
      5'b01100: begin op1 = it.r1; op2 = it.r2; end
      default:  begin op1 = 0;     op2 = 0;     end
    endcase
  endfunction
  always @(negedge clk) begin
    item_t it;
    logic [31:0] e1, e2;
    if (rst || bus.flush) q.delete();
    else begin
      chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, q.size() != 0});
      if (bus.ex_valid && bus.ex_ready && q.size() != 0) begin
        it = q.pop_front();
        model(it, e1, e2);
        chk("opcode", {27'd0, bus.ex_opcode}, {27'd0, it.instr[6:2]});
        chk("func3", {29'd0, bus.ex_func3}, {29'd0, it.instr[14:12]});
        chk("func7", {31'd0, bus.ex_func7}, {31'd0, it.instr[30]});
        chk("rd", {27'd0, bus.ex_rd}, {27'd0, it.instr[11:7]});
        chk("pc", bus.ex_pc, it.pc);
        chk("op1", bus.ex_op1, e1);
        chk("op2", bus.ex_op2, e2);
        chk("store", bus.ex_store, it.r2);
      end
      for (int i = 0; i < q.size(); i++) q[i] = apply_wb(q[i], bus.wb_en, bus.wb_rd, bus.wb_data);
      if (bus.in_valid && bus.in_ready)
        q.push_back(apply_wb('{bus.in_instr, bus.in_pc, bus.in_rs1_data, bus.in_rs2_data},
                             bus.wb_en, bus.wb_rd, bus.wb_data));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid    = 1'b1;
    bus.in_instr    = instr;
    bus.in_pc       = pc;
    bus.in_rs1_data = r1;
    bus.in_rs2_data = r2;
  endtask
  initial begin
    logic [4:0] opcs [10];
    opcs = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b11100};
    bus.flush = 0; bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.ex_ready = 1;
    step(); step();
    chk("rst_valid", {31'd0, bus.ex_valid}, 0);
    chk("rst_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_op1", bus.ex_op1, 0);
    chk("rst_pc", bus.ex_pc, 0);
    rst = 0;
    step();
    offer(32'h0050_0093, 32'h0, 32'h0, 32'h0); step();
    chk("addi_valid", {31'd0, bus.ex_valid}, 1);
    chk("addi_opc", {27'd0, bus.ex_opcode}, 32'h04);
    chk("addi_op2", bus.ex_op2, 5);
    offer(32'h1234_5297, 32'h100, 32'h0, 32'h0); step();
    chk("auipc_op1", bus.ex_op1, 32'h100);
    chk("auipc_op2", bus.ex_op2, 32'h1234_5000);
    offer(32'hABCD_E337, 32'h104, 32'h99, 32'h0); step();
    chk("lui_op1", bus.ex_op1, 0);
    offer(32'hFE20_8CE3, 32'h108, 32'h11, 32'h77); step();
    chk("beq_op2", bus.ex_op2, 32'h77);
    offer(32'h0100_00EF, 32'h40, 32'h0, 32'h0); step();
    chk("jal_op1", bus.ex_op1, 32'h40);
    chk("jal_op2", bus.ex_op2, 16);
    bus.in_valid = 0; step();
    bus.ex_ready = 0;
    offer(32'h0010_0113, 32'h300, 0, 0); step();
    offer(32'h0020_0193, 32'h304, 0, 0); step();
    chk("stall_ready", {31'd0, bus.in_ready}, 0);
    offer(32'h0030_0213, 32'h308, 0, 0); step();
    chk("stall_ready2", {31'd0, bus.in_ready}, 0);
    chk("stall_pc", bus.ex_pc, 32'h300);
    bus.in_valid = 0; bus.ex_ready = 1; step();
    chk("release_pc", bus.ex_pc, 32'h304);
    step();
    bus.ex_ready = 0;
    offer(32'h0020_81B3, 32'h200, 32'h0, 32'h5); step();
    bus.in_valid = 0; bus.wb_en = 1; bus.wb_rd = 1; bus.wb_data = 32'hDEAD; step();
    chk("snoop_op1", bus.ex_op1, 32'hDEAD);
    bus.wb_rd = 0; bus.wb_data = 32'hBEEF; step();
    chk("snoop_x0", bus.ex_op1, 32'hDEAD);
    bus.wb_rd = 2; bus.wb_data = 32'h55;
    offer(32'h0020_8233, 32'h204, 32'h7, 32'h1); step();
    bus.wb_en = 0; bus.in_valid = 0;
    chk("snoop_op2", bus.ex_op2, 32'h55);
    bus.ex_ready = 1; step();
    chk("bypass_pc", bus.ex_pc, 32'h204);
    chk("bypass_op2", bus.ex_op2, 32'h55);
    chk("bypass_op1", bus.ex_op1, 32'h7);
    step();
    bus.ex_ready = 0;
    offer(32'h0050_0093, 32'h400, 0, 0); step();
    offer(32'h0050_0093, 32'h404, 0, 0); step();
    offer(32'h0050_0093, 32'h408, 0, 0); bus.flush = 1; step();
    bus.flush = 0; bus.in_valid = 0;
    chk("flush_valid", {31'd0, bus.ex_valid}, 0);
    chk("flush_ready", {31'd0, bus.in_ready}, 1);
    bus.ex_ready = 1; step();
    chk("flush_drop", {31'd0, bus.ex_valid}, 0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = {opcs[$urandom_range(0, 9)], 2'b11};
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.in_instr = ins; bus.in_pc = $urandom; bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom;
      bus.ex_ready = $urandom_range(0, 2) != 0;
      bus.flush = $urandom_range(0, 29) == 0;
      bus.wb_en = $urandom_range(0, 1) == 1; bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
      step();
    end
    bus.in_valid = 0; bus.flush = 0; bus.wb_en = 0; bus.ex_ready = 1;
    for (int n = 0; n < 10 && q.size() != 0; n++) step();
    step();
    chk("drain", q.size(), 0);
    bus.ex_ready = 0;
    offer(32'h0050_0093, 32'h500, 0, 0); step();
    offer(32'h0050_0093, 32'h504, 0, 0); step();
    bus.in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_valid", {31'd0, bus.ex_valid}, 0);
    chk("arst_ready", {31'd0, bus.in_ready}, 1);
    chk("arst_op1", bus.ex_op1, 0);
    chk("arst_pc", bus.ex_pc, 0);
    chk("arst_opc", {27'd0, bus.ex_opcode}, 0);
    step(); step();
    rst = 0;
    step();
    chk("post_rst_ready", {31'd0, bus.in_ready}, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
